// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and a
// multi-cycle line-wide memory using a req/ack handshake. Hits complete combinationally.
module dcache_controller #(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p1_req_i,
    input  logic                  p1_write_i,
    input  logic [31:0]           p1_addr_i,
    input  logic [31:0]           p1_data_i,
    output logic [31:0]           p1_data_o,
    output logic                  p1_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 32 - 5 - IDX;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        FILL,
        FILL_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [BLOCK_BITS-1:0] data_ram [LINES];
    logic [TAG_W-1:0]      tag_ram  [LINES];
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;

    logic [TAG_W-1:0]      tag;
    logic [IDX-1:0]        index;
    logic [2:0]            word;
    logic [BLOCK_BITS-1:0] line;
    logic [31:0]           line_word;
    logic                  hit;
    logic                  fill_ack;
    logic                  store_hit;
    logic                  unused_addr_bits;

    assign tag              = p1_addr_i[31:5+IDX];
    assign index            = p1_addr_i[4+IDX:5];
    assign word             = p1_addr_i[4:2];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    assign line      = data_ram[index];
    assign line_word = line[int'(word)*32 +: 32];
    assign hit       = valid[index] & (tag_ram[index] == tag);

    assign fill_ack  = (state == FILL) & mem_ack_i & ~rst_i;
    assign store_hit = p1_req_i & p1_write_i & hit & ~rst_i;

    assign p1_stall_o = p1_req_i & ~hit & ~rst_i;
    assign p1_data_o  = (p1_req_i & hit & ~rst_i) ? line_word : 32'h0;

    // NOTE: every variable written in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (p1_req_i && !hit) next_state = MISS;
            MISS:      next_state = (valid[index] && dirty[index]) ? WRITEBACK : FILL;
            WRITEBACK: if (mem_ack_i) next_state = FILL;
            FILL:      if (mem_ack_i) next_state = FILL_DONE;
            FILL_DONE: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Memory-side outputs are registered from next_state so they are valid on entering the state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'h0;
            mem_data_o   <= '0;
        end else begin
            state        <= next_state;
            mem_enable_o <= (next_state == WRITEBACK) || (next_state == FILL);
            mem_write_o  <= (next_state == WRITEBACK);
            if (next_state == WRITEBACK) begin
                mem_addr_o <= {tag_ram[index], index, 5'b0};
                mem_data_o <= line;
            end else if (next_state == FILL) begin
                mem_addr_o <= {tag, index, 5'b0};
            end
            if (fill_ack) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (store_hit) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // NOTE: data and tag storage carry no reset; valid bits alone decide whether contents are used.
    always_ff @(posedge clk_i) begin
        if (fill_ack) begin
            data_ram[index] <= mem_data_i;
            tag_ram[index]  <= tag;
        end else if (store_hit) begin
            data_ram[index][int'(word)*32 +: 32] <= p1_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller; the bench itself plays the memory,
// raising mem_ack_i at hand-chosen cycles and comparing against hand-computed lines.
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_assert = 0;
    int n_fail   = 0;

    dcache_controller #(.LINES(32), .BLOCK_BITS(256)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p1_req_i    (p1_req_i),
        .p1_write_i  (p1_write_i),
        .p1_addr_i   (p1_addr_i),
        .p1_data_i   (p1_data_i),
        .p1_data_o   (p1_data_o),
        .p1_stall_o  (p1_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // The pipeline must keep its request up for as long as a memory transaction is open.
    always @(negedge clk_i) begin
        if (!rst_i && mem_enable_o) begin
            assert (p1_req_i === 1'b1) else begin
                n_fail++;
                $error("FAIL req_dropped observed=%b expected=1", p1_req_i);
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    logic [255:0] line1, line2, line3, line4, line5, exp_wb;
    logic         held_ok;

    initial begin
        rst_i = 1'b1; p1_req_i = 1'b0; p1_write_i = 1'b0;
        p1_addr_i = 32'h0; p1_data_i = 32'h0; mem_ack_i = 1'b0; mem_data_i = '0;
        line1 = make_line(32'h1000_0000);
        line1[31:0] = 32'hDEAD_BEEF;
        line2 = make_line(32'hA000_0000);
        line3 = make_line(32'hB000_0000);
        line4 = make_line(32'hC000_0000);
        line5 = make_line(32'hD000_0000);

        // Reset state
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("rst_enable", mem_enable_o, 0);
        check("rst_write",  mem_write_o, 0);
        check("rst_addr",   mem_addr_o, 0);
        check("rst_mdata",  mem_data_o, 0);
        check("rst_pdata",  p1_data_o, 0);
        check("rst_stall",  p1_stall_o, 0);

        // 1: cold read of 0x40, ack after 10 FILL cycles
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h40;
        #1;
        check("t1_stall_same_cycle", p1_stall_o, 1);
        check("t1_pdata_on_miss", p1_data_o, 0);
        tick();
        check("t1_miss_no_enable", mem_enable_o, 0);
        tick();
        check("t1_fill_enable", mem_enable_o, 1);
        check("t1_fill_write", mem_write_o, 0);
        check("t1_fill_addr", mem_addr_o, 32'h40);
        held_ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h40) held_ok = 1'b0;
        end
        check("t1_fill_held", held_ok, 1);
        mem_ack_i = 1'b1; mem_data_i = line1;
        tick();
        mem_ack_i = 1'b0;
        check("t1_fdone_data", p1_data_o, 32'hDEAD_BEEF);
        check("t1_fdone_stall", p1_stall_o, 0);
        check("t1_fdone_enable", mem_enable_o, 0);
        tick();

        // 2: immediate hit on 0x44
        p1_addr_i = 32'h44;
        #1;
        check("t2_stall", p1_stall_o, 0);
        check("t2_data", p1_data_o, 32'h1000_0001);
        tick();
        check("t2_enable", mem_enable_o, 0);

        // 3: write hit 0x48, then conflicting read 0x448 forces a writeback
        p1_write_i = 1'b1; p1_addr_i = 32'h48; p1_data_i = 32'h1234_5678;
        #1;
        check("t3_store_stall", p1_stall_o, 0);
        tick();
        p1_write_i = 1'b0;
        #1;
        check("t3_store_readback", p1_data_o, 32'h1234_5678);
        p1_addr_i = 32'h448;
        #1;
        check("t3_conflict_stall", p1_stall_o, 1);
        tick();
        tick();
        exp_wb = line1;
        exp_wb[95:64] = 32'h1234_5678;
        check("t3_wb_enable", mem_enable_o, 1);
        check("t3_wb_write", mem_write_o, 1);
        check("t3_wb_addr", mem_addr_o, 32'h40);
        check("t3_wb_data", mem_data_o, exp_wb);
        tick();
        check("t3_wb_held", mem_write_o, 1);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("t3_fill_enable", mem_enable_o, 1);
        check("t3_fill_write", mem_write_o, 0);
        check("t3_fill_addr", mem_addr_o, 32'h440);
        tick();
        mem_ack_i = 1'b1; mem_data_i = line2;
        tick();
        mem_ack_i = 1'b0;
        check("t3_fdone_data", p1_data_o, 32'hA000_0002);
        check("t3_fdone_stall", p1_stall_o, 0);
        tick();

        // 4: read conflict on the now-clean line: straight to FILL, one burst
        p1_addr_i = 32'h40;
        #1;
        check("t4_stall", p1_stall_o, 1);
        tick();
        check("t4_miss_no_enable", mem_enable_o, 0);
        tick();
        check("t4_fill_enable", mem_enable_o, 1);
        check("t4_no_writeback", mem_write_o, 0);
        check("t4_fill_addr", mem_addr_o, 32'h40);
        mem_ack_i = 1'b1; mem_data_i = line3;
        tick();
        mem_ack_i = 1'b0;
        check("t4_fdone_enable", mem_enable_o, 0);
        check("t4_fdone_data", p1_data_o, 32'hB000_0000);
        tick();
        check("t4_single_burst", mem_enable_o, 0);

        // 5: reset during FILL abandons the transaction and invalidates everything
        p1_addr_i = 32'h80;
        #1;
        check("t5_stall", p1_stall_o, 1);
        tick();
        tick();
        check("t5_fill_enable", mem_enable_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t5_rst_enable", mem_enable_o, 0);
        check("t5_rst_addr", mem_addr_o, 0);
        #1;
        check("t5_rereq_miss", p1_stall_o, 1);
        p1_addr_i = 32'h44;
        #1;
        check("t5_old_line_invalid", p1_stall_o, 1);
        p1_req_i = 1'b0;
        #1;
        check("t5_idle_stall", p1_stall_o, 0);
        check("t5_idle_data", p1_data_o, 0);
        tick();
        check("t5_still_idle", mem_enable_o, 0);

        // 6: write miss to 0x100, ack after 1 cycle, store merged and line dirty
        p1_req_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h100; p1_data_i = 32'hCAFE_F00D;
        #1;
        check("t6_stall", p1_stall_o, 1);
        tick();
        tick();
        check("t6_fill_addr", mem_addr_o, 32'h100);
        check("t6_fill_write", mem_write_o, 0);
        tick();
        mem_ack_i = 1'b1; mem_data_i = line4;
        tick();
        mem_ack_i = 1'b0;
        check("t6_fdone_stall", p1_stall_o, 0);
        tick();
        p1_write_i = 1'b0;
        #1;
        check("t6_read_stall", p1_stall_o, 0);
        check("t6_read_data", p1_data_o, 32'hCAFE_F00D);
        p1_addr_i = 32'h500;
        #1;
        check("t6_conflict_stall", p1_stall_o, 1);
        tick();
        tick();
        exp_wb = line4;
        exp_wb[31:0] = 32'hCAFE_F00D;
        check("t6_wb_write", mem_write_o, 1);
        check("t6_wb_addr", mem_addr_o, 32'h100);
        check("t6_wb_data", mem_data_o, exp_wb);
        mem_ack_i = 1'b1;
        tick();
        check("t6_fill_addr2", mem_addr_o, 32'h500);
        mem_data_i = line5;
        tick();
        mem_ack_i = 1'b0;
        check("t6_fdone_data", p1_data_o, 32'hD000_0000);
        tick();
        p1_req_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
